// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage F/D/E/M/W core.
// Produces E-stage forwarding selects and per-stage stall/flush strobes.
// Freezes F/D/E while the iterative multiplier runs.
// Counts stalled fetch cycles in a saturating performance counter.
module pipe_hazard_ctrl #(
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned PERF_W     = 16
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic [3:0]        Ra1D,
  input  logic [3:0]        Ra2D,
  input  logic [3:0]        Ra1E,
  input  logic [3:0]        Ra2E,
  input  logic [3:0]        WA3E,
  input  logic [3:0]        WA3M,
  input  logic [3:0]        WA3W,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              MemtoRegE,
  input  logic              BranchTakenE,
  input  logic              PCSrcD,
  input  logic              PCSrcE,
  input  logic              PCSrcM,
  input  logic              MulStartE,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushM,
  output logic              MulBusy,
  output logic              MulDoneE,
  output logic [PERF_W-1:0] StallCount
);

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_MUL = 1'b1
  } state_t;

  // Countdown start: reaching zero marks the last of the MUL_CYCLES-1 freeze cycles.
  localparam logic [3:0] CNT_INIT = 4'(MUL_CYCLES - 2);

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic [PERF_W-1:0] r_stall_cnt;
  logic              w_ldstall;
  logic              w_pcpend;

  // Forwarding selects: the M-stage result is younger, so it wins over W.
  always_comb begin
    ForwardAE = 2'b00;
    if (RegWriteM && (WA3M == Ra1E))      ForwardAE = 2'b10;
    else if (RegWriteW && (WA3W == Ra1E)) ForwardAE = 2'b01;
    ForwardBE = 2'b00;
    if (RegWriteM && (WA3M == Ra2E))      ForwardBE = 2'b10;
    else if (RegWriteW && (WA3W == Ra2E)) ForwardBE = 2'b01;
  end

  // Stall/flush strobes: fixed freeze pattern in MUL, hazard decode in RUN.
  always_comb begin
    w_ldstall = MemtoRegE && ((WA3E == Ra1D) || (WA3E == Ra2D));
    w_pcpend  = PCSrcD || PCSrcE || PCSrcM;
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushM    = 1'b0;
    MulBusy   = 1'b0;
    MulDoneE  = 1'b0;
    if (r_state == ST_MUL) begin
      StallF   = 1'b1;
      StallD   = 1'b1;
      StallE   = 1'b1;
      FlushM   = 1'b1;
      MulBusy  = 1'b1;
      MulDoneE = (r_cnt == '0);
    end else begin
      StallF = w_ldstall || w_pcpend;
      // A taken branch squashes the D instruction, so holding it is pointless.
      StallD = w_ldstall && !BranchTakenE;
      FlushD = w_pcpend || BranchTakenE;
      FlushE = w_ldstall || BranchTakenE;
    end
  end

  // Multiply freeze sequencer.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_state <= ST_RUN;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (MulStartE) begin
            r_state <= ST_MUL;
            r_cnt   <= CNT_INIT;
          end
        end
        ST_MUL: begin
          if (r_cnt == '0) r_state <= ST_RUN;
          else             r_cnt   <= r_cnt - 4'd1;
        end
        default: begin
          r_state <= ST_RUN;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Saturating count of cycles with fetch stalled.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_stall_cnt <= '0;
    end else if (StallF && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + PERF_W'(1);
    end
  end

  assign StallCount = r_stall_cnt;

endmodule
